// File: rtl/inst_decode_stage.sv
// inst_decode_stage: queued RV32 decode stage with HALT FSM and event counters; DECODE_RV32M_DIV_EN enables DIV/DIVU/REM/REMU
`ifndef INST_DECODE_DEFS
`define INST_DECODE_DEFS
`define ALU_OPA_IS_REGA  2'd0
`define ALU_OPA_IS_NPC   2'd1
`define ALU_OPA_IS_PC    2'd2
`define ALU_OPA_IS_ZR    2'd3
`define ALU_OPB_IS_REGB  2'd0
`define ALU_OPB_IS_I_IMM 2'd1
`define ALU_OPB_IS_SB_IMM 2'd2
`define ALU_OPB_IS_UJ_IMM 2'd3
`define DEST_NONE        1'b0
`define DEST_IS_REGC     1'b1
`define ALU_ADD    5'd0
`define ALU_SUB    5'd1
`define ALU_SLT    5'd2
`define ALU_SLTU   5'd3
`define ALU_AND    5'd4
`define ALU_OR     5'd5
`define ALU_XOR    5'd6
`define ALU_SLL    5'd7
`define ALU_SRL    5'd8
`define ALU_SRA    5'd9
`define ALU_MUL    5'd10
`define ALU_MULH   5'd11
`define ALU_MULHSU 5'd12
`define ALU_MULHU  5'd13
`define ALU_DIV    5'd14
`define ALU_DIVU   5'd15
`define ALU_REM    5'd16
`define ALU_REMU   5'd17
`endif

module inst_decode_stage #(
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [1:0]       opa_select,
  output logic [1:0]       opb_select,
  output logic             dest_reg,
  output logic [4:0]       alu_func,
  output logic             rd_mem,
  output logic             wr_mem,
  output logic             cond_branch,
  output logic             uncond_branch,
  output logic             halt,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] dec_count,
  output logic [CNT_W-1:0] ill_count
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [31:0] q_inst [QDEPTH];
  logic [31:0] q_pc [QDEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [0:0] state;
  logic push, load, consume;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [11:0] imm;
  logic [1:0] d_opa, d_opb;
  logic d_dest, d_rd, d_wr, d_cb, d_ub, d_halt, d_ill;
  logic [4:0] d_alu;

  assign op       = q_inst[rp][6:0];
  assign f3       = q_inst[rp][14:12];
  assign f7       = q_inst[rp][31:25];
  assign imm      = q_inst[rp][31:20];
  assign in_ready = (state == RUN) && (count < FULL);
  assign push     = in_valid && in_ready;
  assign load     = |count && (state == RUN) && (!out_valid || out_ready);
  assign consume  = out_valid && out_ready;
  assign halted   = state == HALT;

  // decode the queue head; anything illegal collapses to the noop control set
  always_comb begin
    d_opa  = `ALU_OPA_IS_REGA;
    d_opb  = `ALU_OPB_IS_REGB;
    d_dest = `DEST_NONE;
    d_alu  = `ALU_ADD;
    d_rd   = 1'b0;
    d_wr   = 1'b0;
    d_cb   = 1'b0;
    d_ub   = 1'b0;
    d_halt = 1'b0;
    d_ill  = 1'b0;
    case (op)
      7'b0110011: begin
        d_dest = `DEST_IS_REGC;
        case ({f7, f3})
          {7'h00, 3'd0}: d_alu = `ALU_ADD;
          {7'h20, 3'd0}: d_alu = `ALU_SUB;
          {7'h00, 3'd1}: d_alu = `ALU_SLL;
          {7'h00, 3'd2}: d_alu = `ALU_SLT;
          {7'h00, 3'd3}: d_alu = `ALU_SLTU;
          {7'h00, 3'd4}: d_alu = `ALU_XOR;
          {7'h00, 3'd5}: d_alu = `ALU_SRL;
          {7'h20, 3'd5}: d_alu = `ALU_SRA;
          {7'h00, 3'd6}: d_alu = `ALU_OR;
          {7'h00, 3'd7}: d_alu = `ALU_AND;
          {7'h01, 3'd0}: d_alu = `ALU_MUL;
          {7'h01, 3'd1}: d_alu = `ALU_MULH;
          {7'h01, 3'd2}: d_alu = `ALU_MULHSU;
          {7'h01, 3'd3}: d_alu = `ALU_MULHU;
`ifdef DECODE_RV32M_DIV_EN
          {7'h01, 3'd4}: d_alu = `ALU_DIV;
          {7'h01, 3'd5}: d_alu = `ALU_DIVU;
          {7'h01, 3'd6}: d_alu = `ALU_REM;
          {7'h01, 3'd7}: d_alu = `ALU_REMU;
`endif
          default:       d_ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        d_dest = `DEST_IS_REGC;
        d_opb  = `ALU_OPB_IS_I_IMM;
        case (f3)
          3'd0:    d_alu = `ALU_ADD;
          3'd1:    d_alu = `ALU_SLL;
          3'd2:    d_alu = `ALU_SLT;
          3'd3:    d_alu = `ALU_SLTU;
          3'd4:    d_alu = `ALU_XOR;
          3'd5:    d_alu = |f7 ? `ALU_SRA : `ALU_SRL;
          3'd6:    d_alu = `ALU_OR;
          default: d_alu = `ALU_AND;
        endcase
      end
      7'b0000011: begin
        d_dest = `DEST_IS_REGC;
        d_opb  = `ALU_OPB_IS_I_IMM;
        d_rd   = 1'b1;
        d_ill  = f3 != 3'd2;
      end
      7'b0100011: begin
        d_opb = `ALU_OPB_IS_SB_IMM;
        d_wr  = 1'b1;
        d_ill = f3 != 3'd2;
      end
      7'b1100011: begin
        d_opa = `ALU_OPA_IS_PC;
        d_opb = `ALU_OPB_IS_SB_IMM;
        d_cb  = 1'b1;
        d_ill = f3[2:1] == 2'b01;
      end
      7'b1101111: begin
        d_opa  = `ALU_OPA_IS_PC;
        d_opb  = `ALU_OPB_IS_UJ_IMM;
        d_dest = `DEST_IS_REGC;
        d_ub   = 1'b1;
      end
      7'b1100111: begin
        d_opb  = `ALU_OPB_IS_I_IMM;
        d_dest = `DEST_IS_REGC;
        d_ub   = 1'b1;
        d_ill  = |f3;
      end
      7'b0110111: begin
        d_opa  = `ALU_OPA_IS_ZR;
        d_opb  = `ALU_OPB_IS_UJ_IMM;
        d_dest = `DEST_IS_REGC;
      end
      7'b0010111: begin
        d_opa  = `ALU_OPA_IS_PC;
        d_opb  = `ALU_OPB_IS_UJ_IMM;
        d_dest = `DEST_IS_REGC;
      end
      7'b1110011: begin
        d_halt = imm == 12'd1;
        d_ill  = imm != 12'd1;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_opa  = `ALU_OPA_IS_REGA;
      d_opb  = `ALU_OPB_IS_REGB;
      d_dest = `DEST_NONE;
      d_alu  = `ALU_ADD;
      d_rd   = 1'b0;
      d_wr   = 1'b0;
      d_cb   = 1'b0;
      d_ub   = 1'b0;
    end
  end

  // queue storage; validity is tracked by pointers and count, so no reset needed
  always_ff @(posedge clock) begin
    if (push) begin
      q_inst[wp] <= in_inst;
      q_pc[wp]   <= in_pc;
    end
  end

  // queue pointers, output slot, RUN/HALT state and event counters
  always_ff @(posedge clock) begin
    if (reset) begin
      wp            <= '0;
      rp            <= '0;
      count         <= '0;
      state         <= RUN;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_inst      <= '0;
      opa_select    <= `ALU_OPA_IS_REGA;
      opb_select    <= `ALU_OPB_IS_REGB;
      dest_reg      <= `DEST_NONE;
      alu_func      <= `ALU_ADD;
      rd_mem        <= 1'b0;
      wr_mem        <= 1'b0;
      cond_branch   <= 1'b0;
      uncond_branch <= 1'b0;
      halt          <= 1'b0;
      illegal       <= 1'b0;
      dec_count     <= '0;
      ill_count     <= '0;
    end else if (flush) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      state     <= RUN;
    end else begin
      wp    <= wp + AW'(push);
      rp    <= rp + AW'(load);
      count <= count + (AW+1)'(push) - (AW+1)'(load);
      if (load) begin
        out_valid     <= 1'b1;
        out_pc        <= q_pc[rp];
        out_inst      <= q_inst[rp];
        opa_select    <= d_opa;
        opb_select    <= d_opb;
        dest_reg      <= d_dest;
        alu_func      <= d_alu;
        rd_mem        <= d_rd;
        wr_mem        <= d_wr;
        cond_branch   <= d_cb;
        uncond_branch <= d_ub;
        halt          <= d_halt;
        illegal       <= d_ill;
        if (d_ill || d_halt) state <= HALT;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
      if (consume) begin
        ill_count <= ill_count + CNT_W'(illegal);
        dec_count <= dec_count + CNT_W'(!illegal);
      end
    end
  end
endmodule

// File: tb/tb_inst_decode_stage.sv
// tb_inst_decode_stage: scoreboard bench for inst_decode_stage (honours DECODE_RV32M_DIV_EN)
module tb_inst_decode_stage;
  localparam logic [1:0] A_REGA = 2'd0, A_PC = 2'd2, A_ZR = 2'd3;
  localparam logic [1:0] B_I = 2'd1, B_SB = 2'd2, B_UJ = 2'd3;
  localparam logic [4:0] F_ADD = 5'd0, F_SUB = 5'd1, F_SLT = 5'd2, F_SLTU = 5'd3, F_AND = 5'd4,
                         F_OR = 5'd5, F_XOR = 5'd6, F_SLL = 5'd7, F_SRL = 5'd8, F_SRA = 5'd9,
                         F_MUL = 5'd10, F_MULH = 5'd11, F_MULHSU = 5'd12, F_MULHU = 5'd13,
                         F_DIV = 5'd14, F_DIVU = 5'd15, F_REM = 5'd16, F_REMU = 5'd17;
  localparam logic [4:0] BASE_TAB [8] = '{F_ADD, F_SLL, F_SLT, F_SLTU, F_XOR, F_SRL, F_OR, F_AND};
  localparam logic [4:0] M_TAB [8] = '{F_MUL, F_MULH, F_MULHSU, F_MULHU, F_DIV, F_DIVU, F_REM, F_REMU};
`ifdef DECODE_RV32M_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [31:0] W_ADD = 32'h00208133, W_DIV = 32'h0220C1B3,
                          W_EBRK = 32'h00100073, W_LD = 32'h0000B083;

  typedef struct packed {
    logic [1:0] opa;
    logic [1:0] opb;
    logic       dest;
    logic [4:0] alu;
    logic       rd, wr, cb, ub, hlt, ill;
  } ctl_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    ctl_t        c;
  } exp_t;

  logic clock, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_inst;
  logic [1:0] opa_select, opb_select;
  logic dest_reg, rd_mem, wr_mem, cond_branch, uncond_branch, halt, illegal, halted;
  logic [4:0] alu_func;
  logic [31:0] dec_count, ill_count;

  int checks = 0, errors = 0;
  exp_t sb [$];
  logic [31:0] m_dec = '0, m_ill = '0;
  bit mon_en = 1'b0;
  int exp_dec = 0, exp_ill = 0;

  inst_decode_stage #(.QDEPTH(4), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .opa_select(opa_select), .opb_select(opb_select), .dest_reg(dest_reg), .alu_func(alu_func),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .cond_branch(cond_branch), .uncond_branch(uncond_branch),
    .halt(halt), .illegal(illegal), .halted(halted),
    .dec_count(dec_count), .ill_count(ill_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ctl_t ref_dec(input logic [31:0] w);
    ctl_t c;
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    c = '0;
    if (op == 7'h33) begin
      c.dest = 1'b1;
      if (f7 == 7'h00) c.alu = BASE_TAB[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) c.alu = F_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) c.alu = F_SRA;
      else if (f7 == 7'h01 && (f3 < 3'd4 || DIV_EN)) c.alu = M_TAB[f3];
      else c.ill = 1'b1;
    end else if (op == 7'h13) begin
      c.dest = 1'b1; c.opb = B_I;
      c.alu = (f3 == 3'd5 && f7 != 7'h00) ? F_SRA : BASE_TAB[f3];
    end else if (op == 7'h03) begin
      c.dest = 1'b1; c.opb = B_I; c.rd = 1'b1; c.ill = f3 != 3'd2;
    end else if (op == 7'h23) begin
      c.opb = B_SB; c.wr = 1'b1; c.ill = f3 != 3'd2;
    end else if (op == 7'h63) begin
      c.opa = A_PC; c.opb = B_SB; c.cb = 1'b1; c.ill = (f3 == 3'd2) || (f3 == 3'd3);
    end else if (op == 7'h6F) begin
      c.opa = A_PC; c.opb = B_UJ; c.dest = 1'b1; c.ub = 1'b1;
    end else if (op == 7'h67) begin
      c.opb = B_I; c.dest = 1'b1; c.ub = 1'b1; c.ill = f3 != 3'd0;
    end else if (op == 7'h37) begin
      c.opa = A_ZR; c.opb = B_UJ; c.dest = 1'b1;
    end else if (op == 7'h17) begin
      c.opa = A_PC; c.opb = B_UJ; c.dest = 1'b1;
    end else if (op == 7'h73) begin
      if (w[31:20] == 12'd1) c.hlt = 1'b1;
      else c.ill = 1'b1;
    end else c.ill = 1'b1;
    if (c.ill) begin
      c = '0;
      c.ill = 1'b1;
    end
    return c;
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: ;
        endcase
      end
      1: w[6:0] = 7'h13;
      2: begin w[6:0] = 7'h03; if ($urandom_range(0, 1) == 0) w[14:12] = 3'd2; end
      3: begin w[6:0] = 7'h23; if ($urandom_range(0, 1) == 0) w[14:12] = 3'd2; end
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h6F;
      6: begin w[6:0] = 7'h67; if ($urandom_range(0, 1) == 0) w[14:12] = 3'd0; end
      7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;
      9: begin w[6:0] = 7'h73; if ($urandom_range(0, 1) == 0) w[31:20] = 12'd1; end
      10: begin w[6:0] = 7'h33; w[31:25] = 7'h00; end
      default: ;
    endcase
    return w;
  endfunction

  // monitor: counters vs model, then pop/compare consumed slots, then record accepted words
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (!reset) begin
        chk("mon_dec_count", 64'(dec_count), 64'(m_dec));
        chk("mon_ill_count", 64'(ill_count), 64'(m_ill));
      end
      if (reset) begin
        sb.delete();
        m_dec = '0;
        m_ill = '0;
      end else if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("mon_spurious_out", 64'(out_pc), 64'hDEAD);
          end else begin
            e = sb.pop_front();
            chk("mon_pc", 64'(out_pc), 64'(e.pc));
            chk("mon_inst", 64'(out_inst), 64'(e.inst));
            chk("mon_ctl", 64'({opa_select, opb_select, dest_reg, alu_func, rd_mem, wr_mem,
                               cond_branch, uncond_branch, halt, illegal}), 64'(e.c));
            chk("mon_halted", 64'(halted), 64'(e.c.hlt | e.c.ill));
            if (e.c.ill) m_ill = m_ill + 32'd1;
            else m_dec = m_dec + 32'd1;
          end
        end
        if (in_valid && in_ready) begin
          e.pc = in_pc;
          e.inst = in_inst;
          e.c = ref_dec(in_inst);
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [31:0] p);
    int n = 0;
    in_valid = 1'b1;
    in_inst = w;
    in_pc = p;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) chk("push_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk(nm, 64'(out_valid), 64'd1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int acc;
    bit take, seen;
    logic [31:0] pc;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) tick();
    reset = 1'b0;
    mon_en = 1'b1;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_ctl", 64'({opa_select, opb_select, dest_reg, alu_func, rd_mem, wr_mem,
                       cond_branch, uncond_branch, halt, illegal}), 64'd0);
    chk("rst_dec_count", 64'(dec_count), 64'd0);
    chk("rst_ill_count", 64'(ill_count), 64'd0);

    out_ready = 1'b1;
    push_word(W_ADD, 32'h100);
    chk("add_not_yet", 64'(out_valid), 64'd0);
    tick();
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_alu", 64'(alu_func), 64'(F_ADD));
    chk("add_dest", 64'(dest_reg), 64'd1);
    tick();
    exp_dec++;
    chk("add_consumed", 64'(out_valid), 64'd0);
    chk("add_dec_count", 64'(dec_count), 64'(exp_dec));

    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = acc < 6;
      in_inst = W_ADD;
      in_pc = 32'h200 + 32'(acc * 4);
      take = in_valid && in_ready;
      tick();
      if (take) acc++;
    end
    in_valid = 1'b0;
    chk("fill_accepted", 64'(acc), 64'd5);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_out_valid", 64'(out_valid), 64'd1);
    chk("fill_head_pc", 64'(out_pc), 64'h200);
    out_ready = 1'b1;
    push_word(W_ADD, 32'h200 + 32'(acc * 4));
    for (int n = 0; n < 30 && sb.size() != 0; n++) tick();
    tick();
    exp_dec += 6;
    chk("fill_drained", 64'(sb.size()), 64'd0);
    chk("fill_dec_count", 64'(dec_count), 64'(exp_dec));

    out_ready = 1'b0;
    push_word(W_DIV, 32'h300);
    wait_valid("div_valid");
    chk("div_illegal", 64'(illegal), 64'(!DIV_EN));
    chk("div_alu", 64'(alu_func), 64'(DIV_EN ? F_DIV : F_ADD));
    chk("div_dest", 64'(dest_reg), 64'(DIV_EN));
    chk("div_halted", 64'(halted), 64'(!DIV_EN));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (DIV_EN) exp_dec++;
    else exp_ill++;
    chk("div_dec_count", 64'(dec_count), 64'(exp_dec));
    chk("div_ill_count", 64'(ill_count), 64'(exp_ill));
    pulse_flush();
    chk("div_flush_halted", 64'(halted), 64'd0);

    push_word(W_EBRK, 32'h400);
    push_word(W_ADD, 32'h404);
    wait_valid("ebrk_valid");
    chk("ebrk_halt", 64'(halt), 64'd1);
    chk("ebrk_illegal", 64'(illegal), 64'd0);
    tick();
    chk("ebrk_halted", 64'(halted), 64'd1);
    chk("ebrk_in_ready", 64'(in_ready), 64'd0);
    chk("ebrk_still_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    seen = 1'b0;
    tick();
    exp_dec++;
    repeat (5) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("ebrk_no_second", 64'(seen), 64'd0);
    chk("ebrk_dec_count", 64'(dec_count), 64'(exp_dec));
    pulse_flush();
    chk("ebrk_flush_halted", 64'(halted), 64'd0);
    chk("ebrk_flush_in_ready", 64'(in_ready), 64'd1);
    repeat (3) tick();
    chk("ebrk_queue_empty", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    push_word(W_LD, 32'h500);
    wait_valid("ld_valid");
    chk("ld_illegal", 64'(illegal), 64'd1);
    chk("ld_rd_mem", 64'(rd_mem), 64'd0);
    out_ready = 1'b1;
    pulse_flush();
    out_ready = 1'b0;
    chk("ld_flush_ill_count", 64'(ill_count), 64'(exp_ill));
    chk("ld_flush_dec_count", 64'(dec_count), 64'(exp_dec));
    chk("ld_flush_out_valid", 64'(out_valid), 64'd0);
    chk("ld_flush_halted", 64'(halted), 64'd0);

    for (int k = 0; k < 3; k++) push_word(W_ADD, 32'h600 + 32'(k * 4));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_dec_count", 64'(dec_count), 64'd0);
    chk("mid_rst_ill_count", 64'(ill_count), 64'd0);
    repeat (3) tick();
    chk("mid_rst_dropped", 64'(out_valid), 64'd0);

    pc = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_inst = gen_word();
      in_pc = pc;
      pc = pc + 32'd4;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 29) == 0;
      reset = $urandom_range(0, 499) == 0;
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 40 && sb.size() != 0 && !halted; n++) tick();
    tick();
    chk("final_drain", 64'(sb.size() == 0 || halted), 64'd1);
    pulse_flush();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
